alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have these ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous active-low reset.
REQ-003 in_valid  input  1  request present on Operation/SrcA/SrcB.
REQ-004 in_ready  output  1  unit can accept a request.
REQ-005 Operation  input  4  ALU operation code from the ALU controller.
REQ-006 SrcA  input  32  operand A (rs1).
REQ-007 SrcB  input  32  operand B (rs2 or immediate).
REQ-008 out_valid  output  1  ALUResult/BrTaken valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 ALUResult  output  32  operation result.
REQ-011 BrTaken  output  1  branch condition true; 0 for non-branch ops.

Function
REQ-012 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1100 SLT (signed), 1000 BEQ, 1001 BNE, 1010 BLT (signed), 1011 BGE (signed).
REQ-013 Arithmetic SHALL be 32-bit, wrap modulo 2^32, no overflow flag; shift amount SHALL be SrcB[4:0] only.
REQ-014 SLT SHALL return 32'd1 if signed SrcA<SrcB, else 32'd0.
REQ-015 Branch opcodes SHALL return ALUResult=32'd0 and BrTaken = condition.
REQ-016 Undefined opcodes (1101, 1110, 1111) SHALL return ALUResult=0, BrTaken=0, with normal latency 1.
REQ-017 FSM states SHALL be IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-018 Request accepted when in_valid && in_ready; operands and opcode SHALL be registered at acceptance and later input changes ignored.
REQ-019 IDLE -> DONE on accepting a non-shift op, or a shift op with shamt 0; result presented next cycle (latency 1).
REQ-020 IDLE -> SHIFT on accepting SLL/SRL/SRA with shamt n>0; one bit position per cycle, down-counter loaded with n.
REQ-021 SHIFT -> DONE when counter reaches 1 and last bit shifted; out_valid rises exactly n+1 cycles after acceptance.
REQ-022 SRA SHALL replicate operand bit 31 each step; SRL/SLL SHALL insert zeros.
REQ-023 In DONE, out_valid=1 and ALUResult/BrTaken held stable until out_ready=1; DONE -> IDLE on out_valid && out_ready.
REQ-024 No new request accepted in the cycle a result is consumed (in_ready low in DONE); next acceptance earliest the following cycle.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-026 With rst_n=0 at a rising edge: state=IDLE, counter=0, out_valid=0, ALUResult=0, BrTaken=0; in_ready=1 from the first cycle after reset release.
REQ-027 Reset during SHIFT or DONE SHALL abandon the operation with no result produced.

Configuration
REQ-028 Macro ALU_SEQ_FAST_SHIFT_EN: defined -> shifts use a single-cycle barrel shifter, all ops latency 1, SHIFT state unreachable; undefined -> iterative shifting per REQ-020..022.

Structure
REQ-029 Package alu_pkg SHALL hold the 4-bit opcode enum (REQ-012), XLEN=32, and the FSM state enum.
REQ-030 Iterative shifter SHALL be sub-module alu_shift_unit (load, step, direction, arithmetic flag, 32-bit value out).

Verification
REQ-031 ADD 0x7FFFFFFF+0x00000001 -> ALUResult 0x80000000, out_valid 1 cycle after accept.
REQ-032 SRA SrcA=0x80000000, SrcB=4 -> 0xF8000000, out_valid 5 cycles after accept (1 cycle with macro defined).
REQ-033 SLL SrcB=0x00000020 (shamt 0) -> ALUResult=SrcA, latency 1.
REQ-034 BLT SrcA=0xFFFFFFFF, SrcB=0x00000001 -> BrTaken=1, ALUResult=0; BGE same operands -> BrTaken=0.
REQ-035 out_ready held 0 for 3 cycles after SUB 5-7 -> ALUResult 0xFFFFFFFE stable, in_ready 0 throughout; accepted on out_ready=1.
REQ-036 rst_n=0 mid-SHIFT (SLL shamt 31) -> next cycle out_valid=0, in_ready=1, ALUResult=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
// Holds the opcode and FSM state enums, the result struct and the
// combinational evaluator used for single-cycle operations.
// Optional feature macro: ALU_SEQ_FAST_SHIFT_EN (barrel shifter for shifts).
package alu_pkg;

   localparam int XLEN = 32;
   localparam int SHW  = 5;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_XOR = 4'b0011,
      OP_SLL = 4'b0100,
      OP_SRL = 4'b0101,
      OP_SUB = 4'b0110,
      OP_SRA = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_BNE = 4'b1001,
      OP_BLT = 4'b1010,
      OP_BGE = 4'b1011,
      OP_SLT = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic            br_taken;
   } alu_rsp_t;

   // True for the three shift opcodes.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // Single-cycle evaluation. In the iterative build a shift only reaches
   // this path with a zero shift amount, so it simply passes operand A and
   // no barrel shifter is built.
   function automatic alu_rsp_t alu_eval(input logic [3:0]      op,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
      alu_rsp_t r;
`ifdef ALU_SEQ_FAST_SHIFT_EN
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
`endif
      r = '0;
      case (op)
         OP_AND: r.result = a & b;
         OP_OR:  r.result = a | b;
         OP_ADD: r.result = a + b;
         OP_XOR: r.result = a ^ b;
         OP_SUB: r.result = a - b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
         OP_SLL: r.result = a << sh;
         OP_SRL: r.result = a >> sh;
         OP_SRA: r.result = $unsigned($signed(a) >>> sh);
`else
         OP_SLL: r.result = a;
         OP_SRL: r.result = a;
         OP_SRA: r.result = a;
`endif
         OP_SLT: r.result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_BEQ: r.br_taken = (a == b);
         OP_BNE: r.br_taken = (a != b);
         OP_BLT: r.br_taken = ($signed(a) < $signed(b));
         OP_BGE: r.br_taken = ($signed(a) >= $signed(b));
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: one-bit-per-cycle shifter.
// load captures the operand and direction; each step moves one position.
module alu_shift_unit
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic            left,
   input  logic            arith,
   input  logic [XLEN-1:0] load_val,
   output logic [XLEN-1:0] value
);

   logic left_q;
   logic arith_q;

   // Capture operand on load, then shift one position per step.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value   <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         value   <= load_val;
         left_q  <= left;
         arith_q <= arith;
      end else if (step) begin
         if (left_q)
            value <= {value[XLEN-2:0], 1'b0};
         else
            value <= {arith_q & value[XLEN-1], value[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: valid/ready ALU with iterative shifts.
// Non-shift ops (and zero-amount shifts) complete in one cycle; shifts by
// n>0 walk through the SHIFT state, one bit per cycle.
// Optional feature macro: ALU_SEQ_FAST_SHIFT_EN -- all shifts single-cycle.
module alu_seq_unit
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      Operation,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUResult,
   output logic            BrTaken
);

   alu_state_e      state;
   logic [SHW-1:0]  count;
   logic [XLEN-1:0] res_q;
   logic            sel_shift;
   logic            accept;
   logic            iter_start;
   logic [XLEN-1:0] sh_value;
   alu_rsp_t        rsp;

   assign accept = (state == ST_IDLE) && in_valid;
   assign rsp    = alu_eval(Operation, SrcA, SrcB);

`ifdef ALU_SEQ_FAST_SHIFT_EN
   assign iter_start = 1'b0;
   assign sh_value   = '0;
`else
   assign iter_start = is_shift(Operation) && (SrcB[SHW-1:0] != '0);

   alu_shift_unit u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept && iter_start),
      .step     (state == ST_SHIFT),
      .left     (Operation == OP_SLL),
      .arith    (Operation == OP_SRA),
      .load_val (SrcA),
      .value    (sh_value)
   );
`endif

   // Result comes from the shifter after an iterative shift; both mux inputs
   // and the select are registers, so the output is stable in DONE.
   assign ALUResult = sel_shift ? sh_value : res_q;

   // Control FSM: accept in IDLE, iterate in SHIFT, hold the result in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         count     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         res_q     <= '0;
         BrTaken   <= 1'b0;
         sel_shift <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  in_ready  <= 1'b0;
                  sel_shift <= iter_start;
                  res_q     <= rsp.result;
                  BrTaken   <= rsp.br_taken;
                  if (iter_start) begin
                     state <= ST_SHIFT;
                     count <= SrcB[SHW-1:0];
                  end else begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               count <= count - 1'b1;
               if (count == SHW'(1)) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench for alu_seq_unit.
// Driver pushes model expectations on acceptance; monitor pops on output.
module tb_alu_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        BrTaken;

   typedef struct {
      logic [31:0] res;
      logic        br;
      int          lat;
      int          acc;
      int          stall;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   alu_seq_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .BrTaken   (BrTaken)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model straight from the opcode table.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      int   sh;
      int   sa;
      int   sbv;
      sh  = int'(b & 32'h1f);
      sa  = a;
      sbv = b;
      e.res = 32'd0;
      e.br  = 1'b0;
      case (op)
         4'd0:  e.res = a & b;
         4'd1:  e.res = a | b;
         4'd2:  e.res = a + b;
         4'd3:  e.res = a ^ b;
         4'd4:  e.res = a << sh;
         4'd5:  e.res = a >> sh;
         4'd6:  e.res = a - b;
         4'd7:  e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd12: e.res = (sa < sbv) ? 32'd1 : 32'd0;
         4'd8:  e.br  = (a == b);
         4'd9:  e.br  = (a != b);
         4'd10: e.br  = (sa < sbv);
         4'd11: e.br  = (sa >= sbv);
         default: ;
      endcase
`ifdef ALU_SEQ_FAST_SHIFT_EN
      e.lat = 1;
`else
      e.lat = ((op == 4'd4 || op == 4'd5 || op == 4'd7) && sh != 0) ? sh + 1 : 1;
`endif
      e.acc   = 0;
      e.stall = 0;
      return e;
   endfunction

   task automatic send(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int stall, input bit track);
      int   waitc;
      int   acc;
      exp_t e;
      waitc = 0;
      @(negedge clk);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      while (!in_ready && waitc < 300) begin
         @(negedge clk);
         waitc++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1 within 300 cycles", in_ready);
         in_valid = 1'b0;
      end else begin
         acc = cyc;
         @(posedge clk);
         #1;
         // Scramble inputs: the unit must have captured them already.
         in_valid  = 1'b0;
         SrcA      = $urandom;
         SrcB      = $urandom;
         Operation = 4'($urandom);
         if (track) begin
            e       = model(op, a, b);
            e.acc   = acc;
            e.stall = stall;
            sb.push_back(e);
         end
      end
   endtask

   // Monitor: checks latency, value, stability and handshake rules.
   initial begin
      bit          seen;
      bit          just_popped;
      int          stall_left;
      logic [31:0] hold_r;
      logic        hold_b;
      exp_t        cur;
      seen = 0;
      just_popped = 0;
      stall_left = 0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            seen = 0;
            just_popped = 0;
            out_ready = 1'b0;
         end else begin
            if (just_popped) begin
               checks++;
               if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL post_consume: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
               end
               just_popped = 0;
            end
            if (out_valid === 1'b1) begin
               if (!seen) begin
                  checks++;
                  if (sb.size() == 0) begin
                     errors++;
                     $display("FAIL spurious_out: out_valid=1 with no outstanding request");
                  end else begin
                     cur = sb[0];
                     seen = 1;
                     hold_r = ALUResult;
                     hold_b = BrTaken;
                     stall_left = cur.stall;
                     if (cyc - cur.acc != cur.lat) begin
                        errors++;
                        $display("FAIL latency: got %0d required %0d", cyc - cur.acc, cur.lat);
                     end
                     checks += 2;
                     if (ALUResult !== cur.res) begin
                        errors++;
                        $display("FAIL result: got %h required %h", ALUResult, cur.res);
                     end
                     if (BrTaken !== cur.br) begin
                        errors++;
                        $display("FAIL brtaken: got %0b required %0b", BrTaken, cur.br);
                     end
                  end
               end else begin
                  checks++;
                  if (ALUResult !== hold_r || BrTaken !== hold_b) begin
                     errors++;
                     $display("FAIL hold_stable: got %h/%0b required %h/%0b", ALUResult, BrTaken, hold_r, hold_b);
                  end
               end
               checks++;
               if (in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL in_ready_done: got %0b required 0", in_ready);
               end
               if (stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else begin
                  out_ready = 1'b1;
               end
               if (out_ready && seen) begin
                  void'(sb.pop_front());
                  seen = 0;
                  just_popped = 1;
               end
            end else begin
               if (sb.size() > 0) begin
                  checks++;
                  if (in_ready !== 1'b0) begin
                     errors++;
                     $display("FAIL in_ready_busy: got %0b required 0", in_ready);
                  end
               end
               // Idle out_ready toggling must have no effect.
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Stimulus: directed corner cases, reset abort, then random traffic.
   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          drain;
      rst_n = 1'b0;
      in_valid = 1'b0;
      Operation = 4'd0;
      SrcA = 32'd0;
      SrcB = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd0 || BrTaken !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ov=%0b ir=%0b res=%h br=%0b required 0/1/0/0", out_valid, in_ready, ALUResult, BrTaken);
      end
      @(negedge clk);
      rst_n = 1'b1;

      send(4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 0, 1);
      send(4'd7,  32'h8000_0000, 32'd4,         1, 1);
      send(4'd4,  32'h1234_5678, 32'h0000_0020, 0, 1);
      send(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1);
      send(4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1);
      send(4'd6,  32'd5,         32'd7,         3, 1);
      send(4'd5,  32'h8000_0001, 32'd31,        0, 1);
      send(4'd7,  32'h8000_0000, 32'd31,        2, 1);
      send(4'd4,  32'h0000_0001, 32'd1,         0, 1);
      send(4'd12, 32'h8000_0000, 32'd0,         0, 1);
      send(4'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1);
      send(4'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1);
      send(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
      send(4'd14, 32'h1,         32'h1,         1, 1);
      send(4'd15, 32'h5,         32'h3,         0, 1);

      // Abort a long shift with reset; nothing may come out afterwards.
      drain = 0;
      while (sb.size() > 0 && drain < 500) begin
         @(negedge clk);
         drain++;
      end
      send(4'd4, 32'hFFFF_FFFF, 32'd31, 0, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd0) begin
         errors++;
         $display("FAIL reset_abort: ov=%0b ir=%0b res=%h required 0/1/0", out_valid, in_ready, ALUResult);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if ($urandom_range(0, 7) == 0) b = a;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(op, a, b, $urandom_range(0, 2), 1);
      end

      drain = 0;
      while (sb.size() > 0 && drain < 1000) begin
         @(negedge clk);
         drain++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
